atom_npu_accum: RTL and testbench
=================================

# atom_npu_accum

Result accumulator stage directly downstream of `atom_npu_core`. It consumes the core's 4-bit result on every `done` pulse, treats each result as signed, and sums `VEC_LEN` consecutive results into one dot-product value. It applies optional ReLU and presents the finished value on a valid/ready output port. The core has no backpressure, so results arriving while the output is stalled are dropped and flagged.

## Interface
- `VEC_LEN`, default 4: results per dot-product. Legal range 2..16.
- `ACC_W`, default 8: accumulator and output width, signed two's complement. Must be ≥ 5.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `clear` input 1: synchronous abort/flush. Priority over all other inputs.
- `relu_en` input 1: when 1, negative final sums are output as 0.
- `in_valid` input 1: connected to core `done`. Single-cycle pulse; `in_data` is valid in that cycle.
- `in_data` input 4: core `output_data`, interpreted as signed −8..7.
- `out_valid` output 1: finished sum available.
- `out_ready` input 1: downstream accepts `out_data` when high with `out_valid`.
- `out_data` output ACC_W: finished dot-product value.
- `count` output 4: number of results accumulated in the current vector, 0..VEC_LEN−1.
- `sat` output 1: sticky. The accumulator saturated during any vector since the last clear/reset.
- `drop` output 1: sticky. An `in_valid` was discarded because the output was stalled.

## Operation
- Two states: ACC and HOLD. Reset and `clear` both enter ACC.
- In ACC, on `in_valid`:
  - next = sat_add(acc, sext(in_data)).
  - If `count` < VEC_LEN−1: acc ← next, count ← count+1.
  - If `count` = VEC_LEN−1 (last element): out_data ← (relu_en && next<0) ? 0 : next; out_valid ← 1; acc ← 0; count ← 0; go to HOLD.
- sat_add clamps the sum to [−2^(ACC_W−1), 2^(ACC_W−1)−1]. Any clamp sets `sat`.
- `relu_en` is sampled in the cycle of the last element only.
- In HOLD, `out_data` and `out_valid` are held stable until `out_valid && out_ready`.
  - On handshake: out_valid ← 0, go to ACC.
  - Handshake in the same cycle as `in_valid`: the input is accepted as element 0 of the next vector (acc ← sext(in_data), count ← 1). It is not dropped.
  - `in_valid` without handshake: input discarded, `drop` ← 1, acc/count unchanged.
- `clear` = 1: acc, count, out_valid, out_data, sat and drop all ← 0; state ← ACC. Any `in_valid` or handshake in that cycle is ignored.
- Sticky flags clear only on `clear` or reset.

## Timing
- Reset (async assert, sync to the clock edge after deassert): out_valid=0, out_data=0, count=0, sat=0, drop=0, acc=0, state ACC.
- Latency: `out_valid` rises on the clock edge that samples the last `in_valid`. It is visible the following cycle (1-cycle registered latency).
- `out_valid` never drops without a handshake, except on `clear` or reset.
- Throughput: one input per cycle. With `out_ready` tied high, back-to-back vectors incur no drops.
- `count` and `sat` update on the same edge as the accepted input.
- `drop` updates on the edge of the discarded input.
- Reset asserted mid-vector or in HOLD discards all partial state immediately. No output is produced.

## Test plan
- Basic sum:
  - Stimulus: VEC_LEN=4, relu_en=0, `out_ready`=1, inputs 3, 5, −2 (4'hE), 1 on consecutive cycles.
  - Required: out_valid for 1 cycle with out_data=7; count sequence 1, 2, 3, 0.
- ReLU:
  - Stimulus: inputs −8, −8, 1, 2 with relu_en=1.
  - Required: out_data=0. Same inputs with relu_en=0 give out_data=−13 (8'hF3).
- Stall/drop:
  - Stimulus: complete a vector summing to 4 with `out_ready`=0, then pulse `in_valid` with 6.
  - Required: out_data stays 4, drop=1, count stays 0.
  - Then raise `out_ready`: handshake completes and out_valid falls.
- Simultaneous handshake + input:
  - Stimulus: in HOLD, assert `out_ready` and `in_valid` (data 2) in the same cycle.
  - Required: drop stays 0; count=1; the next vector's sum includes 2.
- Saturation:
  - Stimulus: ACC_W=5, VEC_LEN=4, inputs 7, 7, 7, 7.
  - Required: out_data=15, sat=1. A following vector 1, 1, 1, 1 gives 4 with sat still 1.
- Clear/reset mid-vector:
  - Stimulus: after 2 inputs, pulse `clear` together with `in_valid`.
  - Required: count=0, no output, flags 0.
  - Repeat with `rst_n` low for 1 cycle: all outputs 0 asynchronously.

Source files
------------

// File: rtl/atom_npu_accum.sv
// atom_npu_accum: sums VEC_LEN signed 4-bit core results into one saturating
// dot-product value, applies optional ReLU, and offers the result on a
// valid/ready port. The upstream core cannot be stalled, so inputs that arrive
// while a finished result is still waiting are discarded and flagged.
//
// Output handshake: out_valid/out_data form a standard valid/ready source.
// Once out_valid is high, out_data is held stable and out_valid stays high
// until a cycle with out_valid && out_ready (the transfer cycle); only clear
// or reset may withdraw it. in_valid has no ready: it is a one-cycle strobe.
module atom_npu_accum #(
  parameter int VEC_LEN = 4,
  parameter int ACC_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             relu_en,
  input  logic             in_valid,
  input  logic [3:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [3:0]       count,
  output logic             sat,
  output logic             drop,
  output logic             state_dbg
);

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(VEC_LEN - 1);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [3:0]       count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic             sat_q, sat_d;
  logic             drop_q, drop_d;

  // Sign-extended input and the saturating sum of acc + input.
  logic [ACC_W-1:0] in_sext;
  logic [ACC_W:0]   wide_sum;
  logic             sum_ovf;
  logic [ACC_W-1:0] sat_sum;
  logic [ACC_W-1:0] relu_sum;
  logic             handshake;

  // Widen by one bit so overflow shows up as a mismatch of the top two bits.
  always_comb begin
    in_sext   = {{(ACC_W-4){in_data[3]}}, in_data};
    wide_sum  = {acc_q[ACC_W-1], acc_q} + {in_sext[ACC_W-1], in_sext};
    sum_ovf   = wide_sum[ACC_W] ^ wide_sum[ACC_W-1];
    sat_sum   = wide_sum[ACC_W-1:0];
    if (sum_ovf) begin
      sat_sum = wide_sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end
    relu_sum  = (relu_en && sat_sum[ACC_W-1]) ? '0 : sat_sum;
    handshake = out_valid_q && out_ready;
  end

  // Next-state and register-update decisions; clear overrides everything.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    sat_d       = sat_q;
    drop_d      = drop_q;

    if (clear) begin
      state_d     = ST_ACC;
      acc_d       = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      sat_d       = 1'b0;
      drop_d      = 1'b0;
    end else begin
      unique case (state_q)
        ST_ACC: begin
          if (in_valid) begin
            if (sum_ovf) begin
              sat_d = 1'b1;
            end
            if (count_q == LAST_IDX) begin
              // Last element: publish the result and restart the accumulator.
              out_data_d  = relu_sum;
              out_valid_d = 1'b1;
              acc_d       = '0;
              count_d     = '0;
              state_d     = ST_HOLD;
            end else begin
              acc_d   = sat_sum;
              count_d = count_q + 4'd1;
            end
          end
        end
        ST_HOLD: begin
          if (handshake) begin
            out_valid_d = 1'b0;
            state_d     = ST_ACC;
            // An input landing on the transfer cycle starts the next vector.
            if (in_valid) begin
              acc_d   = in_sext;
              count_d = 4'd1;
            end
          end else if (in_valid) begin
            drop_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_ACC;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sat_q       <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sat_q       <= sat_d;
      drop_q      <= drop_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign count     = count_q;
  assign sat       = sat_q;
  assign drop      = drop_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_atom_npu_accum.sv
// Testbench for atom_npu_accum: two instances (8-bit and 5-bit accumulators)
// share one stimulus stream. A reference model of the vector/hold behaviour
// pushes expected results into queues; a negedge monitor pops on handshake.
module tb_atom_npu_accum;

  localparam int VEC_LEN = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n     = 1'b0;
  logic       clear     = 1'b0;
  logic       relu_en   = 1'b0;
  logic       in_valid  = 1'b0;
  logic [3:0] in_data   = 4'd0;
  logic       out_ready = 1'b0;

  logic       ov8, ov5;
  logic [7:0] od8;
  logic [4:0] od5;
  logic [3:0] cnt8, cnt5;
  logic       sat8, sat5, drp8, drp5, st8, st5;

  atom_npu_accum #(.VEC_LEN(VEC_LEN), .ACC_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .relu_en(relu_en),
    .in_valid(in_valid), .in_data(in_data), .out_valid(ov8),
    .out_ready(out_ready), .out_data(od8), .count(cnt8), .sat(sat8),
    .drop(drp8), .state_dbg(st8)
  );

  atom_npu_accum #(.VEC_LEN(VEC_LEN), .ACC_W(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .relu_en(relu_en),
    .in_valid(in_valid), .in_data(in_data), .out_valid(ov5),
    .out_ready(out_ready), .out_data(od5), .count(cnt5), .sat(sat5),
    .drop(drp5), .state_dbg(st5)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp8_q[$];
  logic [7:0] exp5_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  bit m_hold;
  int m_cnt;
  int m_acc8, m_acc5;
  bit m_sat8, m_sat5, m_drop;

  function automatic int sat_add(input int a, input int b, input int w, output bit clamped);
    int lo, hi, s;
    lo = -(1 << (w - 1));
    hi = (1 << (w - 1)) - 1;
    s  = a + b;
    clamped = 1'b0;
    if (s > hi) begin s = hi; clamped = 1'b1; end
    if (s < lo) begin s = lo; clamped = 1'b1; end
    return s;
  endfunction

  function automatic int to_signed4(input logic [3:0] d);
    return (d >= 8) ? int'(d) - 16 : int'(d);
  endfunction

  task automatic model_reset();
    m_hold = 0; m_cnt = 0; m_acc8 = 0; m_acc5 = 0;
    m_sat8 = 0; m_sat5 = 0; m_drop = 0;
    exp8_q.delete(); exp5_q.delete();
  endtask

  // Effect of one clock edge given this cycle's inputs.
  task automatic model_step(input bit clr, input bit iv, input logic [3:0] d,
                            input bit rdy, input bit relu);
    int x, s8, s5;
    bit c8, c5;
    logic [7:0] v8, v5;
    x = to_signed4(d);
    if (clr) begin
      if (m_hold) begin
        void'(exp8_q.pop_back());
        void'(exp5_q.pop_back());
      end
      m_hold = 0; m_cnt = 0; m_acc8 = 0; m_acc5 = 0;
      m_sat8 = 0; m_sat5 = 0; m_drop = 0;
    end else if (m_hold) begin
      if (rdy) begin
        m_hold = 0;
        if (iv) begin
          m_acc8 = x; m_acc5 = x; m_cnt = 1;
        end
      end else if (iv) begin
        m_drop = 1;
      end
    end else if (iv) begin
      s8 = sat_add(m_acc8, x, 8, c8);
      s5 = sat_add(m_acc5, x, 5, c5);
      if (c8) m_sat8 = 1;
      if (c5) m_sat5 = 1;
      if (m_cnt == VEC_LEN - 1) begin
        if (relu && s8 < 0) s8 = 0;
        if (relu && s5 < 0) s5 = 0;
        v8 = 8'(s8);
        v5 = {3'b000, 5'(s5)};
        exp8_q.push_back(v8);
        exp5_q.push_back(v5);
        m_hold = 1; m_cnt = 0; m_acc8 = 0; m_acc5 = 0;
      end else begin
        m_acc8 = s8; m_acc5 = s5; m_cnt++;
      end
    end
  endtask

  // ---------------- monitor ----------------
  // Inputs change at posedge+2, so negedge sees a settled cycle.
  always @(negedge clk) begin
    if (rst_n && !clear) begin
      if (ov8) begin
        if (exp8_q.size() == 0) check("spurious_out8", 32'(od8), 32'hxxxx);
        else begin
          check("out_data8", 32'(od8), 32'(exp8_q[0]));
          if (out_ready) void'(exp8_q.pop_front());
        end
      end
      if (ov5) begin
        if (exp5_q.size() == 0) check("spurious_out5", 32'(od5), 32'hxxxx);
        else begin
          check("out_data5", 32'({3'b000, od5}), 32'(exp5_q[0]));
          if (out_ready) void'(exp5_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic check_flags();
    check("out_valid8", 32'(ov8), 32'(m_hold));
    check("out_valid5", 32'(ov5), 32'(m_hold));
    check("count8", 32'(cnt8), 32'(m_cnt));
    check("count5", 32'(cnt5), 32'(m_cnt));
    check("sat8", 32'(sat8), 32'(m_sat8));
    check("sat5", 32'(sat5), 32'(m_sat5));
    check("drop8", 32'(drp8), 32'(m_drop));
    check("drop5", 32'(drp5), 32'(m_drop));
  endtask

  // Called at posedge+2; applies inputs for one cycle and checks after the edge.
  task automatic step(input bit iv, input logic [3:0] d, input bit rdy,
                      input bit relu, input bit clr);
    in_valid = iv; in_data = d; out_ready = rdy; relu_en = relu; clear = clr;
    model_step(clr, iv, d, rdy, relu);
    @(posedge clk); #1;
    check_flags();
    #1;
  endtask

  task automatic vec4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                      input logic [3:0] e, input bit rdy, input bit relu);
    step(1, a, rdy, relu, 0);
    step(1, b, rdy, relu, 0);
    step(1, c, rdy, relu, 0);
    step(1, e, rdy, relu, 0);
  endtask

  task automatic idle(input bit rdy);
    step(0, 4'd0, rdy, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check_flags();
    check("reset_out_data8", 32'(od8), 32'd0);
    check("reset_state", 32'(st8), 32'd0);
    #1;

    // Basic sum 3+5-2+1 = 7, ready held high.
    vec4(4'd3, 4'd5, 4'hE, 4'd1, 1, 0);
    idle(1);
    idle(1);

    // ReLU on and off: -8-8+1+2 = -13 (5-bit: -13 fits).
    vec4(4'h8, 4'h8, 4'd1, 4'd2, 1, 1);
    idle(1);
    vec4(4'h8, 4'h8, 4'd1, 4'd2, 1, 0);
    idle(1);

    // Stall: sum 4 held, extra input dropped, then handshake.
    vec4(4'd1, 4'd1, 4'd1, 4'd1, 0, 0);
    step(1, 4'd6, 0, 0, 0);
    idle(0);
    idle(1);
    idle(1);

    // Simultaneous handshake and input: clear flags first.
    step(0, 4'd0, 0, 0, 1);
    vec4(4'd1, 4'd1, 4'd1, 4'd1, 0, 0);
    idle(0);
    step(1, 4'd2, 1, 0, 0);
    step(1, 4'd1, 1, 0, 0);
    step(1, 4'd1, 1, 0, 0);
    step(1, 4'd1, 1, 0, 0);
    idle(1);

    // Saturation: 7*4 clamps to 15 in 5 bits, then 1+1+1+1 = 4 with sat kept.
    vec4(4'd7, 4'd7, 4'd7, 4'd7, 1, 0);
    vec4(4'd1, 4'd1, 4'd1, 4'd1, 1, 0);
    idle(1);
    // Negative saturation in 5 bits: -8*4 -> -16.
    vec4(4'h8, 4'h8, 4'h8, 4'h8, 1, 0);
    idle(1);

    // Clear mid-vector with in_valid in the same cycle.
    step(1, 4'd3, 1, 0, 0);
    step(1, 4'd3, 1, 0, 0);
    step(1, 4'd3, 1, 0, 1);
    check("clear_out_data8", 32'(od8), 32'd0);
    idle(1);

    // Clear while holding a result.
    vec4(4'd2, 4'd2, 4'd2, 4'd2, 0, 0);
    step(0, 4'd0, 1, 0, 1);
    idle(1);

    // Asynchronous reset mid-vector.
    step(1, 4'd5, 1, 0, 0);
    step(1, 4'd5, 1, 0, 0);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    model_reset();
    check("arst_count8", 32'(cnt8), 32'd0);
    check("arst_out_valid8", 32'(ov8), 32'd0);
    check("arst_out_data8", 32'(od8), 32'd0);
    check("arst_sat_drop", 32'({sat8, drp8, sat5, drp5}), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 70), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 99) < 60), $urandom_range(0, 1) == 1,
           $urandom_range(0, 49) == 0);
    end

    // Drain any pending result.
    idle(1);
    idle(1);
    check("queue_drained", 32'(exp8_q.size() + exp5_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Safety bound in case the stimulus process stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
